// File: rtl/serializer_reg_bank.sv
// serializer_reg_bank
//   Parallel-in / serial-out register bank. One frame of N_SAMPLES words is
//   captured in a single recv handshake, then streamed out one word per
//   completed send beat.
//
// Parameters
//   BIT_WIDTH  width of one word (>= 1)
//   N_SAMPLES  words per frame (>= 2)
//   LSB_FIRST  1: word 0 goes out first, 0: word N_SAMPLES-1 goes out first
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   recv_msg  in   N_SAMPLES*BIT_WIDTH parallel frame, word i at [i*BIT_WIDTH +: BIT_WIDTH]
//   recv_val  in   frame valid
//   recv_rdy  out  block can accept a frame (IDLE)
//   send_msg  out  current serial word (0 while IDLE)
//   send_val  out  send_msg valid (SEND)
//   send_rdy  in   downstream accepts the word
module serializer_reg_bank #(
    parameter int BIT_WIDTH = 8,
    parameter int N_SAMPLES = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_next_s;
    logic [IDX_W-1:0]     send_sel_s;
    logic [BIT_WIDTH-1:0] bank_r [N_SAMPLES];
    logic                 bank_we_s;
    logic                 beat_s;

    // Handshake qualifiers: frame capture and completed output beat.
    always_comb begin
        bank_we_s = recv_val & recv_rdy;
        beat_s    = send_val & send_rdy;
    end

    // Bank word currently presented; idx never leaves 0..N_SAMPLES-1, so the
    // reversed index for MSB-first order is always a valid bank entry.
    always_comb begin
        if (LSB_FIRST != 0) begin
            send_sel_s = idx_r;
        end else begin
            send_sel_s = IDX_LAST - idx_r;
        end
    end

    // Next-state and index logic. The index returns to zero explicitly on the
    // last beat instead of wrapping, so unused codes are never visited.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (bank_we_s) begin
                    state_next_s = SEND;
                    idx_next_s   = IDX_ZERO;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (beat_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_next_s = IDLE;
                        idx_next_s   = IDX_ZERO;
                    end else begin
                        idx_next_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_next_s = idx_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = IDX_ZERO;
            end
        endcase
    end

    // Outputs decode from state and bank only: no recv_val -> send_* path and
    // no send_rdy -> recv_rdy path.
    always_comb begin
        recv_rdy = 1'b0;
        send_val = 1'b0;
        send_msg = {BIT_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                recv_rdy = 1'b1;
            end
            SEND: begin
                send_val = 1'b1;
                send_msg = bank_r[send_sel_s];
            end
            default: begin
                recv_rdy = 1'b0;
            end
        endcase
    end

    // FSM state and index registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Sample bank: cleared on reset, all words loaded together on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                bank_r[i] <= {BIT_WIDTH{1'b0}};
            end
        end else if (bank_we_s) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                bank_r[i] <= recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_serializer_reg_bank.sv
// Directed testbench for serializer_reg_bank.
// dut_a: N_SAMPLES=4, LSB first. dut_b: N_SAMPLES=4, MSB first (shares dut_a's
// stimulus). dut_c: N_SAMPLES=5, LSB first (own stimulus).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serializer_reg_bank;

    logic        clk;
    logic        reset;

    logic [31:0] recv_msg_ab;
    logic        recv_val_ab;
    logic        send_rdy_ab;
    logic        recv_rdy_a, send_val_a;
    logic [7:0]  send_msg_a;
    logic        recv_rdy_b, send_val_b;
    logic [7:0]  send_msg_b;

    logic [39:0] recv_msg_c;
    logic        recv_val_c;
    logic        send_rdy_c;
    logic        recv_rdy_c, send_val_c;
    logic [7:0]  send_msg_c;

    int n_checks;
    int n_fails;

    serializer_reg_bank #(.BIT_WIDTH(8), .N_SAMPLES(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg_ab), .recv_val(recv_val_ab), .recv_rdy(recv_rdy_a),
        .send_msg(send_msg_a), .send_val(send_val_a), .send_rdy(send_rdy_ab)
    );

    serializer_reg_bank #(.BIT_WIDTH(8), .N_SAMPLES(4), .LSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg_ab), .recv_val(recv_val_ab), .recv_rdy(recv_rdy_b),
        .send_msg(send_msg_b), .send_val(send_val_b), .send_rdy(send_rdy_ab)
    );

    serializer_reg_bank #(.BIT_WIDTH(8), .N_SAMPLES(5), .LSB_FIRST(1)) dut_c (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg_c), .recv_val(recv_val_c), .recv_rdy(recv_rdy_c),
        .send_msg(send_msg_c), .send_val(send_val_c), .send_rdy(send_rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Word n of a frame (8-bit words), computed by the bench.
    function automatic logic [7:0] word_of(input logic [39:0] frame, input int n);
        logic [39:0] sh;
        sh = frame >> (8 * n);
        return sh[7:0];
    endfunction

    task automatic check_idle_ab(input string tag);
        check_eq({tag, " a.recv_rdy"}, 64'(recv_rdy_a), 64'd1);
        check_eq({tag, " a.send_val"}, 64'(send_val_a), 64'd0);
        check_eq({tag, " a.send_msg"}, 64'(send_msg_a), 64'h0);
        check_eq({tag, " b.recv_rdy"}, 64'(recv_rdy_b), 64'd1);
        check_eq({tag, " b.send_val"}, 64'(send_val_b), 64'd0);
        check_eq({tag, " b.send_msg"}, 64'(send_msg_b), 64'h0);
    endtask

    // Present a frame to dut_a/dut_b for one edge; returns at the falling edge
    // of the cycle in which word 0 is on send_msg.
    task automatic accept_ab(input logic [31:0] frame);
        recv_msg_ab = frame;
        recv_val_ab = 1'b1;
        @(negedge clk);
        recv_val_ab = 1'b0;
    endtask

    logic [31:0] frame;
    logic [39:0] frame1_c;
    logic [39:0] frame2_c;
    logic [6:0]  rdy_pat;
    int          k;

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset       = 1'b1;
        recv_msg_ab = 32'h0;
        recv_val_ab = 1'b0;
        send_rdy_ab = 1'b1;
        recv_msg_c  = 40'h0;
        recv_val_c  = 1'b0;
        send_rdy_c  = 1'b1;

        // Reset for two cycles, then ten idle cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle_ab("reset");
        check_eq("reset c.recv_rdy", 64'(recv_rdy_c), 64'd1);
        check_eq("reset c.send_val", 64'(send_val_c), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle_ab("idle");
        end

        // Basic frame: LSB order on dut_a, MSB order on dut_b.
        frame = 32'h44332211;
        send_rdy_ab = 1'b1;
        accept_ab(frame);
        for (int i = 0; i < 4; i++) begin
            check_eq("basic a.send_val", 64'(send_val_a), 64'd1);
            check_eq("basic a.recv_rdy", 64'(recv_rdy_a), 64'd0);
            check_eq("basic a.send_msg", 64'(send_msg_a), 64'(word_of(40'(frame), i)));
            check_eq("basic b.send_val", 64'(send_val_b), 64'd1);
            check_eq("basic b.send_msg", 64'(send_msg_b), 64'(word_of(40'(frame), 3 - i)));
            @(negedge clk);
        end
        check_idle_ab("basic end");

        // Backpressure with send_rdy 1,0,0,1,0,1,1 and a recv_val pulse mid-frame.
        rdy_pat = 7'b1101001;
        accept_ab(frame);
        k = 0;
        for (int j = 0; j < 7; j++) begin
            check_eq("bp a.send_val", 64'(send_val_a), 64'd1);
            check_eq("bp a.send_msg", 64'(send_msg_a), 64'(word_of(40'(frame), k)));
            send_rdy_ab = rdy_pat[j];
            if (j == 1) begin
                recv_msg_ab = 32'hDEADBEEF;
                recv_val_ab = 1'b1;
                check_eq("bp a.recv_rdy", 64'(recv_rdy_a), 64'd0);
            end else begin
                recv_val_ab = 1'b0;
            end
            @(negedge clk);
            if (rdy_pat[j]) k++;
        end
        recv_val_ab = 1'b0;
        send_rdy_ab = 1'b1;
        check_eq("bp end a.recv_rdy", 64'(recv_rdy_a), 64'd1);
        check_eq("bp end a.send_val", 64'(send_val_a), 64'd0);
        check_eq("bp end a.send_msg", 64'(send_msg_a), 64'h0);
        @(negedge clk);
        check_eq("bp pulse ignored", 64'(send_val_a), 64'd0);

        // Reset mid-frame after 0x22 has been accepted.
        accept_ab(frame);
        check_eq("midrst a.send_msg0", 64'(send_msg_a), 64'h11);
        @(negedge clk);
        check_eq("midrst a.send_msg1", 64'(send_msg_a), 64'h22);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_ab("midrst");
        @(negedge clk);
        check_idle_ab("midrst hold");
        frame = 32'hDDCCBBAA;
        accept_ab(frame);
        for (int i = 0; i < 4; i++) begin
            check_eq("postrst a.send_val", 64'(send_val_a), 64'd1);
            check_eq("postrst a.send_msg", 64'(send_msg_a), 64'(word_of(40'(frame), i)));
            @(negedge clk);
        end
        check_idle_ab("postrst end");

        // N_SAMPLES=5 back-to-back with recv_val held high.
        frame1_c   = 40'h0504030201;
        frame2_c   = 40'hE5E4E3E2E1;
        send_rdy_c = 1'b1;
        recv_msg_c = frame1_c;
        recv_val_c = 1'b1;
        check_eq("b2b c.recv_rdy0", 64'(recv_rdy_c), 64'd1);
        @(negedge clk);
        recv_msg_c = frame2_c;
        for (int i = 0; i < 5; i++) begin
            check_eq("b2b f1 c.send_val", 64'(send_val_c), 64'd1);
            check_eq("b2b f1 c.recv_rdy", 64'(recv_rdy_c), 64'd0);
            check_eq("b2b f1 c.send_msg", 64'(send_msg_c), 64'(word_of(frame1_c, i)));
            check_eq("b2b f1 idx range", 64'(dut_c.idx_r <= 3'd4), 64'd1);
            @(negedge clk);
        end
        // Gap cycle: IDLE, second frame accepted on the coming edge.
        check_eq("b2b gap c.recv_rdy", 64'(recv_rdy_c), 64'd1);
        check_eq("b2b gap c.send_val", 64'(send_val_c), 64'd0);
        @(negedge clk);
        recv_val_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("b2b f2 c.send_val", 64'(send_val_c), 64'd1);
            check_eq("b2b f2 c.send_msg", 64'(send_msg_c), 64'(word_of(frame2_c, i)));
            check_eq("b2b f2 idx range", 64'(dut_c.idx_r <= 3'd4), 64'd1);
            @(negedge clk);
        end
        check_eq("b2b end c.recv_rdy", 64'(recv_rdy_c), 64'd1);
        check_eq("b2b end c.send_val", 64'(send_val_c), 64'd0);
        check_eq("b2b end c.send_msg", 64'(send_msg_c), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
